// File: rtl/unidade_controle_exp6_pkg.sv
// State codes for the game control unit, shared with display/debug logic
// that decodes db_estado.
package unidade_controle_exp6_pkg;

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIO_RODADA  = 4'h2,
        ESPERA         = 4'h3,
        REGISTRA       = 4'h4,
        COMPARA        = 4'h5,
        PROXIMO_END    = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTO     = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERRO       = 4'hE
    } estado_t;

    // Terminal states are the only ones, besides INICIAL, that accept iniciar.
    function automatic logic is_fim(input estado_t e);
        return (e == FIM_ACERTO) || (e == FIM_TIMEOUT) || (e == FIM_ERRO);
    endfunction

endpackage

// File: rtl/unidade_controle_exp6.sv
// Moore control unit for the memory game: sequences rounds, plays and
// end-of-game status from the datapath terminal flags.
module unidade_controle_exp6
    import unidade_controle_exp6_pkg::*;
#(
    parameter bit TIMEOUT_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       fimE,
    input  logic       fimRod,
    input  logic       fimT,
    input  logic       igual,
    input  logic       enderecoIgualRodada,
    input  logic       jogada_feita,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraRod,
    output logic       contaRod,
    output logic       zeraT,
    output logic       contaT,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    estado_t state_q, state_d;

    // Round end is decided by enderecoIgualRodada alone; fimE is not needed.
    logic unused_fime;
    assign unused_fime = fimE;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= INICIAL;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INICIAL:        if (iniciar) state_d = PREPARACAO;
            PREPARACAO:     state_d = INICIO_RODADA;
            INICIO_RODADA:  state_d = ESPERA;
            ESPERA: begin
                // A play arriving together with the timer end still counts.
                if (jogada_feita)            state_d = REGISTRA;
                else if (fimT && TIMEOUT_EN) state_d = FIM_TIMEOUT;
            end
            REGISTRA:       state_d = COMPARA;
            COMPARA: begin
                if (!igual)                    state_d = FIM_ERRO;
                else if (!enderecoIgualRodada) state_d = PROXIMO_END;
                else if (fimRod)               state_d = FIM_ACERTO;
                else                           state_d = PROXIMA_RODADA;
            end
            PROXIMO_END:    state_d = ESPERA;
            PROXIMA_RODADA: state_d = INICIO_RODADA;
            FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO:
                if (iniciar) state_d = PREPARACAO;
            default:        state_d = INICIAL;
        endcase
    end

    always_comb begin
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraRod   = 1'b0;
        contaRod  = 1'b0;
        zeraT     = 1'b0;
        contaT    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = is_fim(state_q);
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        db_estado = state_q;
        case (state_q)
            PREPARACAO: begin
                zeraE   = 1'b1;
                zeraRod = 1'b1;
                zeraR   = 1'b1;
                zeraT   = 1'b1;
            end
            INICIO_RODADA: begin
                zeraE = 1'b1;
                zeraT = 1'b1;
            end
            ESPERA:         contaT = 1'b1;
            REGISTRA: begin
                registraR = 1'b1;
                zeraT     = 1'b1;
            end
            PROXIMO_END:    contaE   = 1'b1;
            PROXIMA_RODADA: contaRod = 1'b1;
            FIM_ACERTO:     acertou  = 1'b1;
            FIM_ERRO:       errou    = 1'b1;
            FIM_TIMEOUT:    timeout  = 1'b1;
            default:        ;
        endcase
    end

endmodule

// File: tb/tb_unidade_controle_exp6.sv
// Directed-vector bench for unidade_controle_exp6; a second instance with the
// timeout exit disabled shares all inputs.
module tb_unidade_controle_exp6;

    logic clock = 1'b0;
    logic reset, iniciar, fimE, fimRod, fimT, igual, enderecoIgualRodada, jogada_feita;

    logic zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraR, registraR;
    logic pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    logic zeraE_b, contaE_b, zeraRod_b, contaRod_b, zeraT_b, contaT_b, zeraR_b, registraR_b;
    logic pronto_b, acertou_b, errou_b, timeout_b;
    logic [3:0] db_estado_b;

    logic [11:0] outs;
    assign outs = {zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraR, registraR,
                   pronto, acertou, errou, timeout};

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    unidade_controle_exp6 #(.TIMEOUT_EN(1'b1)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .fimE(fimE), .fimRod(fimRod),
        .fimT(fimT), .igual(igual), .enderecoIgualRodada(enderecoIgualRodada),
        .jogada_feita(jogada_feita),
        .zeraE(zeraE), .contaE(contaE), .zeraRod(zeraRod), .contaRod(contaRod),
        .zeraT(zeraT), .contaT(contaT), .zeraR(zeraR), .registraR(registraR),
        .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
        .db_estado(db_estado)
    );

    unidade_controle_exp6 #(.TIMEOUT_EN(1'b0)) dut_nt (
        .clock(clock), .reset(reset), .iniciar(iniciar), .fimE(fimE), .fimRod(fimRod),
        .fimT(fimT), .igual(igual), .enderecoIgualRodada(enderecoIgualRodada),
        .jogada_feita(jogada_feita),
        .zeraE(zeraE_b), .contaE(contaE_b), .zeraRod(zeraRod_b), .contaRod(contaRod_b),
        .zeraT(zeraT_b), .contaT(contaT_b), .zeraR(zeraR_b), .registraR(registraR_b),
        .pronto(pronto_b), .acertou(acertou_b), .errou(errou_b), .timeout(timeout_b),
        .db_estado(db_estado_b)
    );

    // Output vector order: zeraE contaE zeraRod contaRod zeraT contaT zeraR registraR
    //                      pronto acertou errou timeout
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; iniciar = 1'b0; fimE = 1'b0; fimRod = 1'b0; fimT = 1'b0;
        igual = 1'b0; enderecoIgualRodada = 1'b0; jogada_feita = 1'b0;
        tick(); tick();
        total++;
        if (db_estado !== 4'h0 || outs !== 12'h000) begin
            bad++;
            $display("FAIL reset: estado=%h outs=%h expected estado=0 outs=000", db_estado, outs);
        end
        reset = 1'b1;
        tick();
        total++;
        if (db_estado !== 4'h0 || db_estado_b !== 4'h0) begin
            bad++;
            $display("FAIL reset_idle: estado=%h/%h expected 0/0", db_estado, db_estado_b);
        end
    endtask

    task automatic test_start();
        logic [3:0]  es [3] = '{4'h1, 4'h2, 4'h3};
        logic [11:0] eo [3] = '{12'hAA0, 12'h880, 12'h040};
        iniciar = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            iniciar = 1'b0;
            total++;
            if (db_estado !== es[i] || outs !== eo[i]) begin
                bad++;
                $display("FAIL start step%0d: estado=%h outs=%h expected estado=%h outs=%h",
                         i, db_estado, outs, es[i], eo[i]);
            end
        end
    endtask

    task automatic test_round0();
        logic [3:0]  es [5] = '{4'h4, 4'h5, 4'h7, 4'h2, 4'h3};
        logic [11:0] eo [5] = '{12'h090, 12'h000, 12'h100, 12'h880, 12'h040};
        jogada_feita = 1'b1; igual = 1'b1; enderecoIgualRodada = 1'b1; fimRod = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            jogada_feita = 1'b0;
            total++;
            if (db_estado !== es[i] || outs !== eo[i]) begin
                bad++;
                $display("FAIL round0 step%0d: estado=%h outs=%h expected estado=%h outs=%h",
                         i, db_estado, outs, es[i], eo[i]);
            end
        end
    endtask

    task automatic test_mid_round();
        logic [3:0]  es [4] = '{4'h4, 4'h5, 4'h6, 4'h3};
        logic [11:0] eo [4] = '{12'h090, 12'h000, 12'h400, 12'h040};
        // iniciar while waiting for a play must not restart the game
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        total++;
        if (db_estado !== 4'h3) begin
            bad++;
            $display("FAIL iniciar_ignored: estado=%h expected 3", db_estado);
        end
        jogada_feita = 1'b1; igual = 1'b1; enderecoIgualRodada = 1'b0; fimE = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            jogada_feita = 1'b0;
            total++;
            if (db_estado !== es[i] || outs !== eo[i]) begin
                bad++;
                $display("FAIL mid_round step%0d: estado=%h outs=%h expected estado=%h outs=%h",
                         i, db_estado, outs, es[i], eo[i]);
            end
        end
        fimE = 1'b0;
    endtask

    task automatic test_error();
        logic [3:0] es [3] = '{4'h1, 4'h2, 4'h3};
        jogada_feita = 1'b1; igual = 1'b0; enderecoIgualRodada = 1'b1;
        tick(); jogada_feita = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            tick();
            total++;
            if (db_estado !== 4'hE || outs !== 12'h00A) begin
                bad++;
                $display("FAIL error_hold cyc%0d: estado=%h outs=%h expected estado=e outs=00a",
                         i, db_estado, outs);
            end
        end
        igual = 1'b1;
        iniciar = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            iniciar = 1'b0;
            total++;
            if (db_estado !== es[i]) begin
                bad++;
                $display("FAIL error_restart step%0d: estado=%h expected %h", i, db_estado, es[i]);
            end
        end
    endtask

    task automatic test_timeout();
        fimT = 1'b1;
        tick();
        fimT = 1'b0;
        total++;
        if (db_estado !== 4'hD || outs !== 12'h009) begin
            bad++;
            $display("FAIL timeout: estado=%h outs=%h expected estado=d outs=009", db_estado, outs);
        end
        total++;
        if (db_estado_b !== 4'h3) begin
            bad++;
            $display("FAIL timeout_disabled: estado=%h expected 3", db_estado_b);
        end
        tick();
        total++;
        if (db_estado !== 4'hD || timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_hold: estado=%h timeout=%b expected d/1", db_estado, timeout);
        end
        // Restart the timed-out instance; the other one stays in ESPERA meanwhile.
        iniciar = 1'b1;
        tick(); iniciar = 1'b0;
        tick(); tick();
        total++;
        if (db_estado !== 4'h3 || db_estado_b !== 4'h3) begin
            bad++;
            $display("FAIL timeout_resync: estado=%h/%h expected 3/3", db_estado, db_estado_b);
        end
        jogada_feita = 1'b1; fimT = 1'b1; igual = 1'b1; enderecoIgualRodada = 1'b0;
        tick();
        jogada_feita = 1'b0; fimT = 1'b0;
        total++;
        if (db_estado !== 4'h4 || db_estado_b !== 4'h4) begin
            bad++;
            $display("FAIL play_beats_timer: estado=%h/%h expected 4/4", db_estado, db_estado_b);
        end
        tick(); tick(); tick();
        total++;
        if (db_estado !== 4'h3 || db_estado_b !== 4'h3) begin
            bad++;
            $display("FAIL play_beats_timer_back: estado=%h/%h expected 3/3", db_estado, db_estado_b);
        end
    endtask

    task automatic test_acerto();
        jogada_feita = 1'b1; igual = 1'b1; enderecoIgualRodada = 1'b1; fimRod = 1'b1;
        tick(); jogada_feita = 1'b0;
        tick(); tick();
        total++;
        if (db_estado !== 4'hA || outs !== 12'h00C) begin
            bad++;
            $display("FAIL acerto: estado=%h outs=%h expected estado=a outs=00c", db_estado, outs);
        end
        tick(); tick();
        total++;
        if (db_estado !== 4'hA || outs !== 12'h00C) begin
            bad++;
            $display("FAIL acerto_hold: estado=%h outs=%h expected estado=a outs=00c", db_estado, outs);
        end
        iniciar = 1'b1;
        tick(); iniciar = 1'b0;
        tick(); tick();
        jogada_feita = 1'b1;
        tick(); jogada_feita = 1'b0;
        tick();
        total++;
        if (db_estado !== 4'h5) begin
            bad++;
            $display("FAIL acerto_compare: estado=%h expected 5", db_estado);
        end
        #3 reset = 1'b0;
        #1;
        total++;
        if (db_estado !== 4'h0 || outs !== 12'h000 || db_estado_b !== 4'h0) begin
            bad++;
            $display("FAIL async_reset: estado=%h outs=%h estado_b=%h expected 0/000/0",
                     db_estado, outs, db_estado_b);
        end
        #1 reset = 1'b1;
        tick();
        total++;
        if (db_estado !== 4'h0) begin
            bad++;
            $display("FAIL after_reset: estado=%h expected 0", db_estado);
        end
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        total++;
        if (db_estado !== 4'h1 || outs !== 12'hAA0) begin
            bad++;
            $display("FAIL after_reset_start: estado=%h outs=%h expected 1/aa0", db_estado, outs);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_round0();
        test_mid_round();
        test_error();
        test_timeout();
        test_acerto();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unidade_controle_exp6.md
UNIDADE_CONTROLE_EXP6 -- requirements
Module: unidade_controle_exp6

Interface
REQ-001 Parameter TIMEOUT_EN, default 1, meaning: 1 enables the timeout exit from ESPERA; 0 ignores fimT.
REQ-002 clock  input  1  system clock; all state changes occur on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 iniciar  input  1  start or restart request.
REQ-005 fimE, fimRod, fimT  input  1 each  terminal flags from the address counter, round counter and timer.
REQ-006 igual, enderecoIgualRodada, jogada_feita  input  1 each  play match, last address of the round, one-cycle play pulse.
REQ-007 zeraE, contaE, zeraRod, contaRod, zeraT, contaT, zeraR, registraR  output  1 each  datapath controls.
REQ-008 pronto, acertou, errou, timeout  output  1 each  end-of-game status.
REQ-009 db_estado  output  4  current state code.

Function
REQ-010 Machine SHALL be Moore; every output SHALL be decoded from the state register only.
REQ-011 State codes SHALL be: INICIAL 0x0, PREPARACAO 0x1, INICIO_RODADA 0x2, ESPERA 0x3, REGISTRA 0x4, COMPARA 0x5, PROXIMO_END 0x6, PROXIMA_RODADA 0x7, FIM_ACERTO 0xA, FIM_TIMEOUT 0xD, FIM_ERRO 0xE; unused codes SHALL go to INICIAL on the next edge.
REQ-012 INICIAL: all outputs 0; iniciar=1 -> PREPARACAO; otherwise hold.
REQ-013 PREPARACAO: zeraE=zeraRod=zeraR=zeraT=1 for exactly one cycle, then -> INICIO_RODADA unconditionally.
REQ-014 INICIO_RODADA: zeraE=zeraT=1 for one cycle, then -> ESPERA.
REQ-015 ESPERA: contaT=1. jogada_feita=1 -> REGISTRA; else fimT=1 with TIMEOUT_EN=1 -> FIM_TIMEOUT; else hold.
REQ-016 If jogada_feita and fimT are both 1 in the same cycle, jogada_feita SHALL win.
REQ-017 REGISTRA: registraR=1 and zeraT=1 for one cycle, then -> COMPARA.
REQ-018 COMPARA (all outputs 0, one cycle), evaluated in priority order: igual=0 -> FIM_ERRO; enderecoIgualRodada=0 -> PROXIMO_END; fimRod=1 -> FIM_ACERTO; otherwise -> PROXIMA_RODADA.
REQ-019 PROXIMO_END: contaE=1 for one cycle, then -> ESPERA.
REQ-020 PROXIMA_RODADA: contaRod=1 for one cycle, then -> INICIO_RODADA.
REQ-021 FIM_ACERTO: pronto=acertou=1. FIM_ERRO: pronto=errou=1. FIM_TIMEOUT: pronto=timeout=1.
REQ-022 In each FIM_* state: iniciar=1 -> PREPARACAO; otherwise hold, keeping the status outputs held.
REQ-023 At most one of acertou, errou and timeout SHALL be 1 at any time.
REQ-024 iniciar SHALL be ignored in every state other than INICIAL and FIM_*.
REQ-025 fimE SHALL be unused for sequencing; round end SHALL be decided only by enderecoIgualRodada.
REQ-026 Latency from iniciar to the first ESPERA cycle SHALL be 3 clocks.
REQ-027 Latency from a jogada_feita pulse to the contaE or contaRod pulse SHALL be 3 clocks.

Reset
REQ-028 reset=0 SHALL force INICIAL immediately and independently of clock; all outputs SHALL be 0 and db_estado SHALL be 0x0.
REQ-029 Assertion of reset in any state mid-game SHALL abandon the game; datapath zeroing occurs only via a later PREPARACAO.
REQ-030 After reset is released, the first transition SHALL occur on a rising clock edge with reset=1.

Structure
REQ-031 The state-code constants SHALL live in a shared package, reused by display/debug logic.
REQ-032 The block SHALL be a single module with no sub-modules: state register, next-state logic, output decode.

Verification
REQ-033 Reset then iniciar=1 for one cycle -> db_estado 0x1, 0x2, 0x3 on successive edges; the zeraE/zeraRod/zeraR/zeraT pulse each last one cycle.
REQ-034 Round 0: jogada_feita with igual=1, enderecoIgualRodada=1, fimRod=0 -> REGISTRA, COMPARA, PROXIMA_RODADA (contaRod=1 for one cycle), INICIO_RODADA.
REQ-035 Mid-round play with igual=1, enderecoIgualRodada=0 -> PROXIMO_END with contaE=1 for one cycle, then back to ESPERA (0x3).
REQ-036 Play with igual=0 -> db_estado=0xE with pronto=errou=1 held for 20 cycles; then iniciar=1 -> 0x1.
REQ-037 Hold in ESPERA and raise fimT -> 0xD with timeout=1; repeat with jogada_feita and fimT in the same cycle -> 0x4; with TIMEOUT_EN=0, fimT alone -> stays 0x3.
REQ-038 Last round, final address, fimRod=1, igual=1 -> 0xA with acertou=1; reset=0 asserted asynchronously in 0x5 -> 0x0 before the next edge.
